// File: rtl/mesi_isc_cpu_port.sv
// CPU-side port of a MESI coherence controller: a master FSM that broadcasts,
// waits for enable and accesses memory, plus a coherence-bus snoop responder.
module mesi_isc_cpu_port #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int SNOOP_LAT      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  input  logic                      req_wr_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  output logic                      req_ready_o,
  output logic                      done_o,
  output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
  input  logic                      mbus_ack_i,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  output logic [7:0]                snoop_cnt_o,
  output logic                      err_o
);

  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP      = MBUS_CMD_WIDTH'(0);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR       = MBUS_CMD_WIDTH'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD       = MBUS_CMD_WIDTH'(2);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);

  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);

  localparam logic [3:0] SNOOP_LAT_M1 = 4'(SNOOP_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BROAD,
    ST_WAIT_EN,
    ST_ACCESS
  } state_t;

  state_t                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rdy_en_q, rdy_en_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    is_snoop_q, is_snoop_d;
  logic                    guard_q, guard_d;
  logic [3:0]              lat_q, lat_d;
  logic [7:0]              snoop_cnt_q, snoop_cnt_d;
  logic                    err_q, err_d;

  logic cmd_legal;
  logic cmd_illegal;
  logic is_en;
  logic en_match;
  logic capture;

  assign cmd_legal   = (cbus_cmd_i != CBUS_NOP) && (cbus_cmd_i <= CBUS_EN_RD);
  assign cmd_illegal = cbus_cmd_i > CBUS_EN_RD;
  assign is_en       = (cbus_cmd_i == CBUS_EN_WR) || (cbus_cmd_i == CBUS_EN_RD);
  assign en_match    = ((cbus_cmd_i == CBUS_EN_WR) == wr_q) && (cbus_addr_i == addr_q);
  assign capture     = cmd_legal && !busy_q && !guard_q;

  // rdy_en_q keeps the port closed for the first cycle after reset.
  assign req_ready_o = (state_q == ST_IDLE) && rdy_en_q && req_valid_i;
  assign cbus_ack_o  = busy_q && (lat_q == 4'd0);
  assign done_o      = done_q;
  assign snoop_cnt_o = snoop_cnt_q;
  assign err_o       = err_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    rdy_en_d    = 1'b1;
    done_d      = 1'b0;
    busy_d      = busy_q;
    is_snoop_d  = is_snoop_q;
    guard_d     = 1'b0;
    lat_d       = lat_q;
    snoop_cnt_d = snoop_cnt_q;
    err_d       = err_q;
    mbus_cmd_o  = MBUS_NOP;
    mbus_addr_o = '0;

    // Snoop responder runs independently of the master FSM.
    if (busy_q) begin
      if (lat_q == 4'd0) begin
        busy_d  = 1'b0;
        guard_d = 1'b1;
        if (is_snoop_q && (snoop_cnt_q != 8'hFF)) snoop_cnt_d = snoop_cnt_q + 8'd1;
      end else begin
        lat_d = lat_q - 4'd1;
      end
    end else if (capture) begin
      busy_d     = 1'b1;
      is_snoop_d = !is_en;
      lat_d      = is_en ? 4'd0 : SNOOP_LAT_M1;
    end

    if (cmd_illegal) err_d = 1'b1;
    if (capture && is_en && ((state_q != ST_WAIT_EN) || !en_match)) err_d = 1'b1;
    if (mbus_ack_i && ((state_q == ST_IDLE) || (state_q == ST_WAIT_EN))) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (req_ready_o) begin
          wr_d    = req_wr_i;
          addr_d  = req_addr_i;
          state_d = ST_BROAD;
        end
      end
      ST_BROAD: begin
        mbus_cmd_o  = wr_q ? MBUS_WR_BROAD : MBUS_RD_BROAD;
        mbus_addr_o = addr_q;
        if (mbus_ack_i) state_d = ST_WAIT_EN;
      end
      ST_WAIT_EN: begin
        // Mismatched enables are acknowledged and flagged but never advance.
        if (capture && is_en && en_match) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        mbus_cmd_o  = wr_q ? MBUS_WR : MBUS_RD;
        mbus_addr_o = addr_q;
        if (mbus_ack_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      rdy_en_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      is_snoop_q  <= 1'b0;
      guard_q     <= 1'b0;
      lat_q       <= 4'd0;
      snoop_cnt_q <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      rdy_en_q    <= rdy_en_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      is_snoop_q  <= is_snoop_d;
      guard_q     <= guard_d;
      lat_q       <= lat_d;
      snoop_cnt_q <= snoop_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mesi_isc_cpu_port.sv
// Bench for mesi_isc_cpu_port: directed scenarios with fixed expectations and a
// randomized run scored against a transaction-level timeline model.
module tb_mesi_isc_cpu_port;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_wr_i;
  logic [31:0] req_addr_i;
  logic        req_ready_o, done_o;
  logic [2:0]  mbus_cmd_o;
  logic [31:0] mbus_addr_o;
  logic        mbus_ack_i;
  logic [2:0]  cbus_cmd_i;
  logic [31:0] cbus_addr_i;
  logic        cbus_ack_o;
  logic [7:0]  snoop_cnt_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  mesi_isc_cpu_port #(
    .ADDR_WIDTH(32), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3), .SNOOP_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o), .done_o(done_o),
    .mbus_cmd_o(mbus_cmd_o), .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
    .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_ack_o(cbus_ack_o),
    .snoop_cnt_o(snoop_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        ready;
    logic        done;
    logic [2:0]  mcmd;
    logic [31:0] maddr;
    logic        cack;
    logic [7:0]  cnt;
    logic        err;
  } obs_t;

  obs_t want;

  // The bus address only carries meaning while a command is driven.
  function automatic obs_t sample();
    obs_t o;
    o.ready = req_ready_o;
    o.done  = done_o;
    o.mcmd  = mbus_cmd_o;
    o.maddr = (mbus_cmd_o == 3'd0) ? 32'd0 : mbus_addr_o;
    o.cack  = cbus_ack_o;
    o.cnt   = snoop_cnt_o;
    o.err   = err_o;
    return o;
  endfunction

  function automatic obs_t mk(logic r, logic d, logic [2:0] c, logic [31:0] a,
                              logic k, logic [7:0] n, logic e);
    obs_t o;
    o.ready = r; o.done = d; o.mcmd = c; o.maddr = a; o.cack = k; o.cnt = n; o.err = e;
    return o;
  endfunction

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic mack, input logic [2:0] cc, input logic [31:0] ca);
    req_valid_i = v; req_wr_i = w; req_addr_i = a;
    mbus_ack_i = mack; cbus_cmd_i = cc; cbus_addr_i = ca;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 32'h55, 1, 3'd1, 32'h55);
    step(); step();
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL reset_outputs: got %h expected %h", sample(), want); end
    n_cmp++;
    if (mbus_addr_o !== 32'd0) begin n_bad++; $display("FAIL reset_mbus_addr: got %h expected 0", mbus_addr_o); end
    step();
    rst = 1'b0;
    drive(1, 1, 32'h55, 0, 0, 0);
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL first_cycle_after_rst: got %h expected %h", sample(), want); end
    step();
    @(negedge clk); want = mk(1, 0, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL ready_second_cycle: got %h expected %h", sample(), want); end
    do_reset();
  endtask

  task automatic test_write();
    do_reset();
    drive(1, 1, 32'h1, 0, 0, 0);
    @(negedge clk); want = mk(1, 0, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL wr_idle: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 0, 3'd3, 32'h1, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL wr_broad1: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 1, 0, 0);
    @(negedge clk); want = mk(0, 0, 3'd3, 32'h1, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL wr_broad2: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 3'd3, 32'h1);
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL wr_wait_en: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 0, 3'd1, 32'h1, 1, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL wr_access_ack: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 1, 0, 0);
    @(negedge clk); want = mk(0, 0, 3'd1, 32'h1, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL wr_access_hold: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 1, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL wr_done: got %h expected %h", sample(), want); end
    step();
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL wr_after_done: got %h expected %h", sample(), want); end
  endtask

  task automatic test_snoop();
    do_reset();
    drive(0, 0, 0, 0, 3'd1, 32'h40);
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sn_lat1: got %h expected %h", sample(), want); end
    step();
    @(negedge clk); want = mk(0, 0, 0, 0, 1, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sn_ack: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 3'd2, 32'h44);
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 1, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sn_guard: got %h expected %h", sample(), want); end
    step();
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 1, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sn_capture2: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 1, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sn_lat2: got %h expected %h", sample(), want); end
    step();
    @(negedge clk); want = mk(0, 0, 0, 0, 1, 1, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sn_ack2: got %h expected %h", sample(), want); end
    step();
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 2, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sn_count2: got %h expected %h", sample(), want); end
  endtask

  task automatic test_snoop_in_broad();
    do_reset();
    drive(1, 0, 32'h20, 0, 0, 0);
    step(); drive(0, 0, 0, 1, 3'd2, 32'h20);
    @(negedge clk); want = mk(0, 0, 3'd4, 32'h20, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sb_broad: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sb_wait: got %h expected %h", sample(), want); end
    step();
    @(negedge clk); want = mk(0, 0, 0, 0, 1, 0, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sb_snoop_ack: got %h expected %h", sample(), want); end
    step(); step(); drive(0, 0, 0, 0, 3'd4, 32'h20);
    step(); drive(0, 0, 0, 1, 0, 0);
    @(negedge clk); want = mk(0, 0, 3'd2, 32'h20, 1, 1, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sb_access: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 1, 0, 0, 0, 1, 0); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL sb_done: got %h expected %h", sample(), want); end
  endtask

  task automatic test_bad_enable();
    do_reset();
    drive(1, 0, 32'h8, 0, 0, 0);
    step(); drive(0, 0, 0, 1, 0, 0);
    step(); drive(0, 0, 0, 0, 3'd3, 32'h7);
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 0, 0, 0, 1, 0, 1); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL be_ack_err: got %h expected %h", sample(), want); end
    step();
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 0, 1); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL be_still_wait: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 3'd4, 32'h8);
    step(); drive(0, 0, 0, 1, 0, 0);
    @(negedge clk); want = mk(0, 0, 3'd2, 32'h8, 1, 0, 1); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL be_access: got %h expected %h", sample(), want); end
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 1, 0, 0, 0, 0, 1); n_cmp++;
    if (sample() !== want) begin n_bad++; $display("FAIL be_done: got %h expected %h", sample(), want); end
  endtask

  task automatic test_bad_cmd();
    do_reset();
    drive(0, 0, 0, 0, 3'd5, 0);
    @(negedge clk); n_cmp++;
    if (err_o !== 1'b0) begin n_bad++; $display("FAIL bc_before: err got %b expected 0", err_o); end
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); n_cmp++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL bc_cmd_gt4: err got %b expected 1", err_o); end
    do_reset();
    drive(0, 0, 0, 1, 0, 0);
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); n_cmp++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL bc_ack_idle: err got %b expected 1", err_o); end
  endtask

  task automatic test_saturate();
    int acks = 0;
    do_reset();
    drive(0, 0, 0, 0, 3'd1, 32'h40);
    for (int i = 0; i < 2000 && acks < 300; i++) begin
      @(negedge clk); n_cmp++;
      if (snoop_cnt_o !== 8'((acks > 255) ? 255 : acks) || err_o !== 1'b0) begin
        n_bad++; $display("FAIL sat_count: got %0d expected %0d after %0d acks", snoop_cnt_o, (acks > 255) ? 255 : acks, acks);
      end
      if (cbus_ack_o === 1'b1) acks++;
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    step(); step(); step();
    @(negedge clk); n_cmp++;
    if (acks !== 300) begin n_bad++; $display("FAIL sat_acks: got %0d expected 300", acks); end
    n_cmp++;
    if (snoop_cnt_o !== 8'd255) begin n_bad++; $display("FAIL sat_final: got %0d expected 255", snoop_cnt_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 1, 32'h3, 0, 0, 0);
    step(); drive(0, 0, 0, 1, 0, 0);
    step(); drive(0, 0, 0, 0, 3'd3, 32'h3);
    step(); drive(0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); want = mk(0, 0, 0, 0, 0, 0, 0); n_cmp++;
    if (sample() !== want || mbus_addr_o !== 32'd0) begin n_bad++; $display("FAIL rm_access_rst: got %h expected %h", sample(), want); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk); n_cmp++;
      if (sample() !== want) begin n_bad++; $display("FAIL rm_access_after %0d: got %h expected %h", i, sample(), want); end
    end
    step();
    drive(0, 0, 0, 0, 3'd1, 32'h40);
    step(); drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); n_cmp++;
      if (sample() !== want) begin n_bad++; $display("FAIL rm_snoop_after %0d: got %h expected %h", i, sample(), want); end
      step();
    end
  endtask

  // Timeline model: each capture schedules its acknowledge and the first cycle
  // the responder may capture again; the master is a four-phase transaction.
  localparam int P_IDLE = 0, P_BROAD = 1, P_WAIT = 2, P_ACCESS = 3;

  task automatic test_random(input int cycles, input bit legal_only);
    int          m_n = 0, m_phase = P_IDLE;
    int          m_ack_at = -1, m_free_at = 0, m_done_at = -1, m_snoops = 0;
    bit          m_wr = 0, m_err = 0, m_ack_snoop = 0;
    logic [31:0] m_addr = 0;
    bit          capt, en, match;
    logic [2:0]  cc, ecmd;
    logic [31:0] eaddr;
    int          r;
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      r  = $urandom % 10;
      cc = 3'd0;
      if (m_phase == P_WAIT && r < 3)  cc = m_wr ? 3'd3 : 3'd4;
      else if (r >= 6 && r < 8)        cc = 3'($urandom_range(1, 2));
      else if (r >= 8 && !legal_only)  cc = 3'($urandom_range(3, 4));
      drive($urandom % 3 == 0, 1'($urandom), $urandom % 4,
            (m_phase == P_BROAD || m_phase == P_ACCESS) ? ($urandom % 3 == 0)
                                                        : (!legal_only && $urandom % 40 == 0),
            cc, (m_phase == P_WAIT && r < 3) ? m_addr : ($urandom % 4));
      @(negedge clk);
      ecmd  = (m_phase == P_BROAD) ? (m_wr ? 3'd3 : 3'd4) : (m_phase == P_ACCESS) ? (m_wr ? 3'd1 : 3'd2) : 3'd0;
      eaddr = (ecmd == 3'd0) ? 32'd0 : m_addr;
      want  = mk(m_phase == P_IDLE && req_valid_i, m_n == m_done_at, ecmd, eaddr,
                 m_n == m_ack_at, 8'(m_snoops), m_err);
      n_cmp++;
      if (sample() !== want) begin n_bad++; $display("FAIL rand cycle %0d: got %h expected %h", i, sample(), want); end
      if (m_n == m_ack_at && m_ack_snoop && m_snoops < 255) m_snoops++;
      capt  = cbus_cmd_i >= 3'd1 && cbus_cmd_i <= 3'd4 && m_n >= m_free_at;
      en    = cbus_cmd_i == 3'd3 || cbus_cmd_i == 3'd4;
      match = ((cbus_cmd_i == 3'd3) == m_wr) && cbus_addr_i == m_addr;
      if (capt && en && !(m_phase == P_WAIT && match)) m_err = 1;
      if (mbus_ack_i && (m_phase == P_IDLE || m_phase == P_WAIT)) m_err = 1;
      if (capt) begin
        m_ack_at    = m_n + (en ? 1 : LAT);
        m_free_at   = m_ack_at + 2;
        m_ack_snoop = !en;
      end
      case (m_phase)
        P_IDLE:   if (req_valid_i) begin m_wr = req_wr_i; m_addr = req_addr_i; m_phase = P_BROAD; end
        P_BROAD:  if (mbus_ack_i) m_phase = P_WAIT;
        P_WAIT:   if (capt && en && match) m_phase = P_ACCESS;
        default:  if (mbus_ack_i) begin m_done_at = m_n + 1; m_phase = P_IDLE; end
      endcase
      m_n++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_write();
    test_snoop();
    test_snoop_in_broad();
    test_bad_enable();
    test_bad_cmd();
    test_saturate();
    test_reset_mid();
    test_random(1500, 1'b1);
    test_random(600, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
